// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the NREQ requesters / clear source and the arbiter.
// The arbiter drives DSEL/RIN straight into the register array.
interface regfile_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int AW   = 3
);
  logic [NREQ-1:0]    REQ;
  logic [NREQ*AW-1:0] REQ_ADDR;
  logic [NREQ*DW-1:0] REQ_DATA;
  logic               CLR_REQ;
  logic [NREQ-1:0]    GNT;
  logic               CLR_BUSY;
  logic [AW-1:0]      DSEL;
  logic [DW-1:0]      RIN;

  modport master (output REQ, REQ_ADDR, REQ_DATA, CLR_REQ,
                  input  GNT, CLR_BUSY, DSEL, RIN);
  modport slave  (input  REQ, REQ_ADDR, REQ_DATA, CLR_REQ,
                  output GNT, CLR_BUSY, DSEL, RIN);
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-array write port, plus a
// one-register-per-cycle clear sweep. Every output comes from a flop.
module regfile_write_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int AW   = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  regfile_write_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST   = PW'(NREQ - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   ptr, ptr_nx;
  logic [NREQ-1:0] gnt, gnt_nx;
  logic            busy, busy_nx;
  logic [AW-1:0]   dsel, dsel_nx;
  logic [DW-1:0]   rin, rin_nx;

  // Rotate requests so bit 0 is the one at PTR; the lowest set bit wins.
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic              found;
  logic [PW-1:0]     off, win;
  logic [PW:0]       sum;
  logic [AW-1:0]     addr_sel;
  logic [DW-1:0]     data_sel;

  assign req_dbl = {bus.REQ, bus.REQ} >> ptr;
  assign req_rot = req_dbl[NREQ-1:0];

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        found = 1'b1;
        off   = PW'(j);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    win = sum[PW-1:0];
    addr_sel = '0;
    data_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == PW'(k)) begin
        addr_sel = bus.REQ_ADDR[k*AW +: AW];
        data_sel = bus.REQ_DATA[k*DW +: DW];
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    gnt_nx   = '0;
    busy_nx  = 1'b0;
    dsel_nx  = '0;
    rin_nx   = rin;
    case (state)
      IDLE: begin
        if (bus.CLR_REQ) begin
          state_nx = CLEAR;
          dsel_nx  = AW'(1);
          rin_nx   = '0;
          busy_nx  = 1'b1;
        end else if (found) begin
          gnt_nx  = NREQ'(1) << win;
          dsel_nx = addr_sel;
          rin_nx  = data_sel;
          ptr_nx  = (win == LAST) ? '0 : win + PW'(1);
        end
      end
      CLEAR: begin
        rin_nx = '0;
        // Top register is being written this cycle: sweep ends.
        if (dsel == '1) begin
          state_nx = IDLE;
        end else begin
          dsel_nx = dsel + AW'(1);
          busy_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
      dsel  <= '0;
      rin   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      gnt   <= gnt_nx;
      busy  <= busy_nx;
      dsel  <= dsel_nx;
      rin   <= rin_nx;
    end
  end

  assign bus.GNT      = gnt;
  assign bus.CLR_BUSY = busy;
  assign bus.DSEL     = dsel;
  assign bus.RIN      = rin;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios then random traffic,
// all checked against a queue/arithmetic reference model.
module tb_regfile_write_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int AW   = 3;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  regfile_write_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();
  regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_ptr;
  int clr_q[$];
  int e_gnt, e_dsel, e_rin, e_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model();
    int k;
    bit hit;
    if (RST) begin
      m_ptr = 0;
      clr_q.delete();
      e_gnt = 0; e_dsel = 0; e_rin = 0; e_busy = 0;
    end else if (clr_q.size() > 0) begin
      // mid-sweep: scripted addresses, 0 marks the return to idle
      e_dsel = clr_q.pop_front();
      e_busy = (e_dsel != 0);
      e_gnt = 0; e_rin = 0;
    end else if (bus.CLR_REQ) begin
      for (int v = 2; v < (1 << AW); v++) clr_q.push_back(v);
      clr_q.push_back(0);
      e_dsel = 1; e_busy = 1; e_gnt = 0; e_rin = 0;
    end else begin
      hit = 0;
      for (int i = 0; i < NREQ; i++) begin
        k = (m_ptr + i) % NREQ;
        if (!hit && bus.REQ[k]) begin
          hit = 1;
          e_gnt  = 1 << k;
          e_dsel = int'(bus.REQ_ADDR[k*AW +: AW]);
          e_rin  = int'(bus.REQ_DATA[k*DW +: DW]);
          m_ptr  = (k + 1) % NREQ;
        end
      end
      if (!hit) begin
        e_gnt = 0; e_dsel = 0;
      end
      e_busy = 0;
    end
  endtask

  task automatic cycle();
    model();
    @(posedge CLK);
    #1;
    chk("gnt",  32'(bus.GNT),      32'(e_gnt));
    chk("dsel", 32'(bus.DSEL),     32'(e_dsel));
    chk("rin",  32'(bus.RIN),      32'(e_rin));
    chk("busy", 32'(bus.CLR_BUSY), 32'(e_busy));
  endtask

  task automatic set_req(input int k, input int addr, input int data);
    bus.REQ_ADDR[k*AW +: AW] = AW'(addr);
    bus.REQ_DATA[k*DW +: DW] = DW'(data);
  endtask

  initial begin
    logic [NREQ-1:0] nreq;
    bus.REQ = '0; bus.REQ_ADDR = '0; bus.REQ_DATA = '0; bus.CLR_REQ = 1'b0;
    #1;

    // reset with all requests asserted
    RST = 1'b1; bus.REQ = 4'b1111;
    cycle();
    chk("rst_dsel", 32'(bus.DSEL), 32'd0);
    cycle();

    // single write
    RST = 1'b0; bus.REQ = 4'b0100;
    set_req(2, 5, 16'hBEEF);
    cycle();
    chk("single_gnt", 32'(bus.GNT), 32'b0100);
    chk("single_rin", 32'(bus.RIN), 32'hBEEF);
    bus.REQ = '0;
    cycle();

    // round robin from PTR=0
    RST = 1'b1; cycle();
    RST = 1'b0; bus.REQ = 4'b1111;
    for (int k = 0; k < NREQ; k++) set_req(k, k + 1, 16'h1000 + k);
    for (int c = 0; c < 8; c++) begin
      cycle();
      chk("rr_seq", 32'(bus.GNT), 32'(1 << (c % NREQ)));
    end

    // clear beats a simultaneous request
    RST = 1'b1; bus.REQ = '0; cycle();
    RST = 1'b0; bus.REQ = 4'b0001; set_req(0, 3, 16'h1234); bus.CLR_REQ = 1'b1;
    cycle();
    bus.CLR_REQ = 1'b0;
    for (int c = 0; c < 8; c++) cycle();
    chk("clr_then_gnt", 32'(bus.GNT), 32'b0001);
    bus.REQ = '0;
    cycle();

    // reset while the sweep is at DSEL=4
    bus.CLR_REQ = 1'b1; cycle();
    bus.CLR_REQ = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    chk("mid_clr_dsel", 32'(bus.DSEL), 32'd4);
    RST = 1'b1; cycle();
    RST = 1'b0; bus.REQ = 4'b0010; set_req(1, 6, 16'h5A5A);
    cycle();

    // address 0 is granted but writes nothing
    bus.REQ = '0; cycle();
    bus.REQ = 4'b0010; set_req(1, 0, 16'hCAFE);
    cycle();
    chk("addr0_dsel", 32'(bus.DSEL), 32'd0);
    bus.REQ = '0; cycle();

    // random traffic; a held, not-yet-granted request keeps its addr/data
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom_range(0, 99) < 2);
      bus.CLR_REQ = ($urandom_range(0, 99) < 4);
      nreq = NREQ'($urandom);
      for (int k = 0; k < NREQ; k++) begin
        if (!(nreq[k] && bus.REQ[k] && !e_gnt[k]))
          set_req(k, int'($urandom_range(0, (1 << AW) - 1)), int'($urandom));
      end
      bus.REQ = nreq;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
